// File: rtl/mpx_wb_arbiter_pkg.sv
// Shared definitions for the MPX writeback path: register index width,
// the hardwired-zero register and the writeback source-select encoding.
package mpx_defs;

    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0]    reg_data_t;

    localparam reg_idx_t REG_ZERO = '0;

    // Which source owns the register file write port this cycle.
    typedef enum logic [1:0] {
        WB_SRC_NONE   = 2'd0,
        WB_SRC_EXEC   = 2'd1,
        WB_SRC_LOAD   = 2'd2,
        WB_SRC_MULDIV = 2'd3
    } wb_src_e;

    // Long-latency writes are the ones that retire scoreboard entries.
    function automatic logic is_long_latency(input wb_src_e src);
        return (src == WB_SRC_LOAD) || (src == WB_SRC_MULDIV);
    endfunction

endpackage

// File: rtl/mpx_wb_arbiter_if.sv
// Writeback bus between the result sources / issue logic and the
// writeback arbiter. The arbiter takes the slave modport; the sources,
// issue stage and register file side take the master modport.
interface mpx_wb_arbiter_if;
    import mpx_defs::*;

    // Execute pipeline result, no backpressure
    logic      exec_valid_i;
    reg_idx_t  exec_rd_i;
    reg_data_t exec_value_i;

    // Load unit result, valid/accept handshake
    logic      load_valid_i;
    reg_idx_t  load_rd_i;
    reg_data_t load_value_i;
    logic      load_accept_o;

    // Mul/div unit result, valid/accept handshake
    logic      muldiv_valid_i;
    reg_idx_t  muldiv_rd_i;
    reg_data_t muldiv_value_i;
    logic      muldiv_accept_o;

    // Issue-side scoreboard access
    logic      alloc_valid_i;
    reg_idx_t  alloc_rd_i;
    reg_idx_t  ra_i;
    reg_idx_t  rb_i;
    logic      ra_pending_o;
    logic      rb_pending_o;

    // Register file write port
    reg_idx_t  rd0_o;
    reg_data_t rd0_value_o;

    modport slave (
        input  exec_valid_i, exec_rd_i, exec_value_i,
        input  load_valid_i, load_rd_i, load_value_i,
        output load_accept_o,
        input  muldiv_valid_i, muldiv_rd_i, muldiv_value_i,
        output muldiv_accept_o,
        input  alloc_valid_i, alloc_rd_i, ra_i, rb_i,
        output ra_pending_o, rb_pending_o,
        output rd0_o, rd0_value_o
    );

    modport master (
        output exec_valid_i, exec_rd_i, exec_value_i,
        output load_valid_i, load_rd_i, load_value_i,
        input  load_accept_o,
        output muldiv_valid_i, muldiv_rd_i, muldiv_value_i,
        input  muldiv_accept_o,
        output alloc_valid_i, alloc_rd_i, ra_i, rb_i,
        input  ra_pending_o, rb_pending_o,
        input  rd0_o, rd0_value_o
    );

endinterface

// File: rtl/mpx_wb_scoreboard.sv
// Pending-write scoreboard for registers 1..NUM_REGS-1. A bit is set when a
// long-latency op is issued to that register and cleared on the edge where
// its writeback commits. Register 0 is never tracked and always reads 0.
module mpx_wb_scoreboard
    import mpx_defs::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     set_valid_i,
    input  reg_idx_t set_rd_i,
    input  logic     clr_valid_i,
    input  reg_idx_t clr_rd_i,
    input  reg_idx_t ra_i,
    input  reg_idx_t rb_i,
    output logic     ra_pending_o,
    output logic     rb_pending_o
);

    logic [NUM_REGS-1:1] pending_d;
    logic [NUM_REGS-1:1] pending_q;

    // Next pending vector: clear applied first so a same-cycle set wins.
    always_comb begin
        pending_d = pending_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (clr_valid_i && (clr_rd_i == i[REG_IDX_W-1:0])) begin
                pending_d[i] = 1'b0;
            end
            if (set_valid_i && (set_rd_i == i[REG_IDX_W-1:0])) begin
                pending_d[i] = 1'b1;
            end
        end
    end

    // Pending vector register; reset drops every outstanding entry.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Two combinational read ports; index 0 or out-of-range reads 0.
    always_comb begin
        ra_pending_o = 1'b0;
        rb_pending_o = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (ra_i == i[REG_IDX_W-1:0]) begin
                ra_pending_o = pending_q[i];
            end
            if (rb_i == i[REG_IDX_W-1:0]) begin
                rb_pending_o = pending_q[i];
            end
        end
    end

endmodule

// File: rtl/mpx_wb_arbiter.sv
// Writeback arbiter for the MPX register file write port.
// Execute results always win; load and mul/div results share the remaining
// slots through a valid/accept handshake. The granted write is registered
// onto rd0_o/rd0_value_o, and long-latency writes retire scoreboard entries
// as they commit.
// Build option: define MPX_WB_FAIR_ARB_EN for round-robin between load and
// mul/div; otherwise load has fixed priority over mul/div.
module mpx_wb_arbiter
    import mpx_defs::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mpx_wb_arbiter_if.slave   bus
);

    wb_src_e   src_sel;
    logic      exec_hit;
    logic      both_req;

    reg_idx_t  rd0_d;
    reg_idx_t  rd0_q;
    reg_data_t rd0_value_d;
    reg_data_t rd0_value_q;
    logic      rd0_ll_d;
    logic      rd0_ll_q;

`ifdef MPX_WB_FAIR_ARB_EN
    // 0: load wins the next contested cycle, 1: mul/div wins it.
    logic      rr_muldiv_d;
    logic      rr_muldiv_q;
`endif

    // Pick the owner of the write port for this cycle.
    always_comb begin
        src_sel  = WB_SRC_NONE;
        exec_hit = bus.exec_valid_i && (bus.exec_rd_i != REG_ZERO);
        both_req = bus.load_valid_i && bus.muldiv_valid_i;
        if (exec_hit) begin
            src_sel = WB_SRC_EXEC;
        end else if (both_req) begin
`ifdef MPX_WB_FAIR_ARB_EN
            src_sel = rr_muldiv_q ? WB_SRC_MULDIV : WB_SRC_LOAD;
`else
            src_sel = WB_SRC_LOAD;
`endif
        end else if (bus.load_valid_i) begin
            src_sel = WB_SRC_LOAD;
        end else if (bus.muldiv_valid_i) begin
            src_sel = WB_SRC_MULDIV;
        end
    end

    // Handshake accepts and the write-port mux for the selected source.
    always_comb begin
        rd0_d               = REG_ZERO;
        rd0_value_d         = '0;
        bus.load_accept_o   = (src_sel == WB_SRC_LOAD);
        bus.muldiv_accept_o = (src_sel == WB_SRC_MULDIV);
        case (src_sel)
            WB_SRC_EXEC: begin
                rd0_d       = bus.exec_rd_i;
                rd0_value_d = bus.exec_value_i;
            end
            WB_SRC_LOAD: begin
                rd0_d       = bus.load_rd_i;
                rd0_value_d = bus.load_value_i;
            end
            WB_SRC_MULDIV: begin
                rd0_d       = bus.muldiv_rd_i;
                rd0_value_d = bus.muldiv_value_i;
            end
            default: begin
                rd0_d       = REG_ZERO;
                rd0_value_d = '0;
            end
        endcase
        // A long-latency result aimed at r0 is accepted but discarded.
        if (rd0_d == REG_ZERO) begin
            rd0_value_d = '0;
        end
        rd0_ll_d = is_long_latency(src_sel) && (rd0_d != REG_ZERO);
    end

    // Write-port output register; reset kills any in-flight write at once.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd0_q       <= REG_ZERO;
            rd0_value_q <= '0;
            rd0_ll_q    <= 1'b0;
        end else begin
            rd0_q       <= rd0_d;
            rd0_value_q <= rd0_value_d;
            rd0_ll_q    <= rd0_ll_d;
        end
    end

`ifdef MPX_WB_FAIR_ARB_EN
    // Flip the round-robin pointer after every contested long-latency grant.
    always_comb begin
        rr_muldiv_d = rr_muldiv_q;
        if (both_req && !exec_hit) begin
            rr_muldiv_d = ~rr_muldiv_q;
        end
    end

    // Round-robin pointer register; starts by favouring load.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rr_muldiv_q <= 1'b0;
        end else begin
            rr_muldiv_q <= rr_muldiv_d;
        end
    end
`endif

    assign bus.rd0_o       = rd0_q;
    assign bus.rd0_value_o = rd0_value_q;

    // The write shown on rd0_o commits at the end of this cycle, so that is
    // the edge where its pending bit is retired.
    mpx_wb_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .set_valid_i  (bus.alloc_valid_i && (bus.alloc_rd_i != REG_ZERO)),
        .set_rd_i     (bus.alloc_rd_i),
        .clr_valid_i  (rd0_ll_q),
        .clr_rd_i     (rd0_q),
        .ra_i         (bus.ra_i),
        .rb_i         (bus.rb_i),
        .ra_pending_o (bus.ra_pending_o),
        .rb_pending_o (bus.rb_pending_o)
    );

endmodule

// File: tb/tb_mpx_wb_arbiter.sv
// Directed bench for mpx_wb_arbiter: expected register-file writes are
// queued as stimulus is issued and a monitor pops them whenever rd0_o
// presents a write. Handshake and scoreboard outputs are checked inline.
module tb_mpx_wb_arbiter;

    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;

    logic [36:0] exp_q[$];

    mpx_wb_arbiter_if bus();

    mpx_wb_arbiter #(
        .NUM_REGS (32)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] val);
        exp_q.push_back({rd, val});
    endtask

    task automatic idle();
        bus.exec_valid_i   = 1'b0;
        bus.exec_rd_i      = '0;
        bus.exec_value_i   = '0;
        bus.load_valid_i   = 1'b0;
        bus.load_rd_i      = '0;
        bus.load_value_i   = '0;
        bus.muldiv_valid_i = 1'b0;
        bus.muldiv_rd_i    = '0;
        bus.muldiv_value_i = '0;
        bus.alloc_valid_i  = 1'b0;
        bus.alloc_rd_i     = '0;
        bus.ra_i           = '0;
        bus.rb_i           = '0;
    endtask

    // Write monitor: every write on rd0_o must match the oldest expectation.
    initial begin
        logic [36:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.rd0_o != 5'd0) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_write: got rd=%0d val=0x%0h expected no write",
                             bus.rd0_o, bus.rd0_value_o);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.rd0_o !== e[36:32] || bus.rd0_value_o !== e[31:0]) begin
                        miscompares++;
                        $display("FAIL write: got rd=%0d val=0x%0h expected rd=%0d val=0x%0h",
                                 bus.rd0_o, bus.rd0_value_o, e[36:32], e[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_load;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        idle();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_rd0", 32'(bus.rd0_o), 32'd0);
        check("reset_val", bus.rd0_value_o, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_load_acc", 32'(bus.load_accept_o), 32'd0);
        check("idle_md_acc", 32'(bus.muldiv_accept_o), 32'd0);
        for (int i = 0; i < 32; i++) begin
            bus.ra_i = 5'(i);
            bus.rb_i = 5'(31 - i);
            #1;
            check("reset_ra_pend", 32'(bus.ra_pending_o), 32'd0);
            check("reset_rb_pend", 32'(bus.rb_pending_o), 32'd0);
        end

        // Exec collision: exec r5 blocks load r6 for one cycle
        step();
        bus.ra_i = '0; bus.rb_i = '0;
        bus.exec_valid_i = 1'b1; bus.exec_rd_i = 5'd5; bus.exec_value_i = 32'h11;
        bus.load_valid_i = 1'b1; bus.load_rd_i = 5'd6; bus.load_value_i = 32'hAA;
        push(5'd5, 32'h11);
        @(negedge clk);
        check("coll_load_acc", 32'(bus.load_accept_o), 32'd0);
        step();
        bus.exec_valid_i = 1'b0;
        push(5'd6, 32'hAA);
        @(negedge clk);
        check("coll_load_acc2", 32'(bus.load_accept_o), 32'd1);
        check("coll_rd0_exec", 32'(bus.rd0_o), 32'd5);

        // Exec to r0 is absent; load to r0 is accepted and discarded
        step();
        bus.exec_valid_i = 1'b1; bus.exec_rd_i = 5'd0; bus.exec_value_i = 32'h55;
        bus.load_valid_i = 1'b1; bus.load_rd_i = 5'd0; bus.load_value_i = 32'h66;
        @(negedge clk);
        check("r0_load_acc", 32'(bus.load_accept_o), 32'd1);
        step();
        idle();
        @(negedge clk);
        check("r0_no_write", 32'(bus.rd0_o), 32'd0);

        // Both long-latency sources held for 4 cycles
        step();
        bus.load_valid_i   = 1'b1; bus.load_rd_i   = 5'd7; bus.load_value_i   = 32'h77;
        bus.muldiv_valid_i = 1'b1; bus.muldiv_rd_i = 5'd8; bus.muldiv_value_i = 32'h88;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
`ifdef MPX_WB_FAIR_ARB_EN
            exp_load = (k % 2 == 0);
`else
            exp_load = 1'b1;
`endif
            check("both_load_acc", 32'(bus.load_accept_o), 32'(exp_load));
            check("both_md_acc", 32'(bus.muldiv_accept_o), 32'(!exp_load));
            if (exp_load) push(5'd7, 32'h77);
            else          push(5'd8, 32'h88);
            step();
        end
        bus.load_valid_i = 1'b0;
        @(negedge clk);
        check("md_alone_acc", 32'(bus.muldiv_accept_o), 32'd1);
        push(5'd8, 32'h88);
        step();
        idle();
        @(negedge clk);

        // Scoreboard lifetime: alloc r9 at cycle 0, load r9 accepted at cycle 3
        step();
        bus.alloc_valid_i = 1'b1; bus.alloc_rd_i = 5'd9; bus.ra_i = 5'd9;
        @(negedge clk);
        check("life_pend_c0", 32'(bus.ra_pending_o), 32'd0);
        check("life_rb0_c0", 32'(bus.rb_pending_o), 32'd0);
        for (int c = 1; c <= 6; c++) begin
            step();
            bus.alloc_valid_i = 1'b0;
            if (c == 3) begin
                bus.load_valid_i = 1'b1; bus.load_rd_i = 5'd9; bus.load_value_i = 32'hDEAD;
            end else begin
                bus.load_valid_i = 1'b0;
            end
            @(negedge clk);
            check("life_pend", 32'(bus.ra_pending_o), 32'(c >= 1 && c <= 4));
            if (c == 3) begin
                check("life_load_acc", 32'(bus.load_accept_o), 32'd1);
                push(5'd9, 32'hDEAD);
            end
            if (c == 4) check("life_rd0", 32'(bus.rd0_o), 32'd9);
        end
        idle();

        // Same-cycle set and clear on r10; exec writes leave pending alone
        step();
        bus.alloc_valid_i = 1'b1; bus.alloc_rd_i = 5'd10; bus.ra_i = 5'd10; bus.rb_i = 5'd0;
        for (int c = 1; c <= 7; c++) begin
            step();
            bus.alloc_valid_i = (c == 3);
            bus.load_valid_i  = (c == 2);
            bus.load_rd_i     = 5'd10; bus.load_value_i = 32'hBB;
            bus.exec_valid_i  = (c == 5);
            bus.exec_rd_i     = 5'd10; bus.exec_value_i = 32'h1010;
            if (c == 2) push(5'd10, 32'hBB);
            if (c == 5) push(5'd10, 32'h1010);
            @(negedge clk);
            if (c == 3) check("sc_rd0", 32'(bus.rd0_o), 32'd10);
            check("sc_pend", 32'(bus.ra_pending_o), 32'd1);
            check("sc_rb0", 32'(bus.rb_pending_o), 32'd0);
        end
        bus.ra_i = 5'd0;
        #1;
        check("sc_ra0", 32'(bus.ra_pending_o), 32'd0);
        idle();

        // Mid-operation reset while rd0_o shows the r12 load write
        step();
        bus.alloc_valid_i = 1'b1; bus.alloc_rd_i = 5'd12; bus.ra_i = 5'd12;
        step();
        bus.alloc_valid_i = 1'b0;
        bus.load_valid_i = 1'b1; bus.load_rd_i = 5'd12; bus.load_value_i = 32'hC12;
        @(negedge clk);
        check("mr_load_acc", 32'(bus.load_accept_o), 32'd1);
        step();
        bus.load_valid_i = 1'b0;
        check("mr_rd0_before", 32'(bus.rd0_o), 32'd12);
        check("mr_pend_before", 32'(bus.ra_pending_o), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mr_rd0_async", 32'(bus.rd0_o), 32'd0);
        check("mr_val_async", bus.rd0_value_o, 32'd0);
        check("mr_pend_clear", 32'(bus.ra_pending_o), 32'd0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("mr_rd0_after", 32'(bus.rd0_o), 32'd0);
            check("mr_pend_after", 32'(bus.ra_pending_o), 32'd0);
        end

        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
